// File: rtl/conv55_seq_ctrl.sv
// Sequencing controller for a 5x5 convolution window: one pixel/coefficient
// pair per beat, a single 8x8 multiplier, and a 21-bit accumulator that is
// presented as a single result per window.
// Optional build macro CONV55_SAT18_EN clamps the result to 18 bits and
// raises out_sat whenever the clamp is applied.
module conv55_seq_ctrl #(
  parameter int TAPS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pix,
  input  logic [7:0]  in_coef,
  output logic [4:0]  tap_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] out_data,
  output logic        out_sat
);

  localparam logic [4:0]  LAST_TAP = 5'(TAPS - 1);
  localparam logic [20:0] SAT_MAX  = 21'd262143;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state;
  logic [20:0] acc;
  logic [15:0] prod;
  logic [20:0] prod_ext;
  logic [20:0] sum_next;
  logic [20:0] res_data;
  logic        res_sat;
  logic        beat;

  always_comb begin
    prod     = in_pix * in_coef;
    prod_ext = {5'd0, prod};
    sum_next = acc + prod_ext;
    beat     = in_valid & in_ready;
  end

`ifdef CONV55_SAT18_EN
  always_comb begin
    if (sum_next > SAT_MAX) begin
      res_data = SAT_MAX;
      res_sat  = 1'b1;
    end else begin
      res_data = sum_next;
      res_sat  = 1'b0;
    end
  end
`else
  always_comb begin
    res_data = sum_next;
    res_sat  = 1'b0;
  end
`endif

  // rst beats clr, and clr beats every handshake, including a beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tap_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      tap_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc     <= prod_ext;
            tap_idx <= 5'd1;
            state   <= ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= sum_next;
            if (tap_idx == LAST_TAP) begin
              state     <= OUT;
              tap_idx   <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= res_data;
              out_sat   <= res_sat;
            end else begin
              tap_idx <= tap_idx + 5'd1;
            end
          end
        end
        OUT: begin
          // Result holds until the consumer takes it; intake stays closed.
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          tap_idx   <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv55_seq_ctrl.md
CONV55_SEQ_CTRL -- requirements
Module: conv55_seq_ctrl

Interface
REQ-001 SHALL have parameter TAPS, default 25, number of pixel/coefficient pairs per window (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port clr, input, 1, synchronous abort of the current window.
REQ-005 SHALL have port in_valid, input, 1, the pixel/coefficient pair is valid.
REQ-006 SHALL have port in_ready, output, 1, the controller accepts a pair.
REQ-007 SHALL have port in_pix, input, 8, unsigned pixel.
REQ-008 SHALL have port in_coef, input, 8, unsigned kernel coefficient.
REQ-009 SHALL have port tap_idx, output, 5, index of the next tap to accept (kernel address).
REQ-010 SHALL have port out_valid, output, 1, the window result is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port out_data, output, 21, window sum of products.
REQ-013 SHALL have port out_sat, output, 1, saturation flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, ACC, OUT.
REQ-015 SHALL transfer a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-016 SHALL drive in_ready=1 in IDLE and ACC and in_ready=0 in OUT.
REQ-017 SHALL use a single 8x8 unsigned multiplier and a 21-bit accumulator; the product is zero-extended, and the accumulator never wraps because 25*255*255=1625625 < 2^21.
REQ-018 On the first beat in IDLE: SHALL load the accumulator with that beat's product (not add to it), set tap_idx=1, and go to ACC.
REQ-019 On each beat in ACC: SHALL add the product to the accumulator and increment tap_idx.
REQ-020 When the accepted beat is tap TAPS-1: SHALL go to OUT next cycle with out_valid=1, out_data=final sum, tap_idx=0.
REQ-021 A cycle with in_valid=0 SHALL leave all state unchanged (bubbles are tolerated).
REQ-022 In OUT, out_data and out_valid SHALL hold stable until out_ready=1; on that handshake the FSM SHALL go to IDLE and drive out_valid=0 the next cycle.
REQ-023 Latency: the result SHALL be visible the cycle after the last beat; minimum window period is TAPS+1 cycles.
REQ-024 clr=1 SHALL return to IDLE, zero the accumulator and tap_idx, drop out_valid, and discard the beat presented in that cycle; clr has priority over every handshake.
REQ-025 A beat presented while out_valid=1 SHALL NOT be accepted (in_ready=0).

Reset
REQ-026 rst SHALL take priority over clr and all handshakes.
REQ-027 On rst the block SHALL go to IDLE with accumulator=0, tap_idx=0, out_valid=0, out_data=0, out_sat=0; in_ready=1 from the first cycle after reset.
REQ-028 Reset mid-window SHALL discard all partial accumulation.

Configuration
REQ-029 Macro CONV55_SAT18_EN:
  - defined: when the final sum exceeds 262143, out_data=262143 and out_sat=1 with the result; otherwise out_sat=0.
  - undefined: out_data is the full 21-bit sum and out_sat is tied to 0.
  - the accumulator is 21 bits in both builds.

Verification
REQ-030 25 beats, pix=1, coef=1, no bubbles, out_ready=1 -> out_valid in cycle 26 with out_data=25; tap_idx sequences 0..24 then 0.
REQ-031 25 beats, pix=255, coef=255 -> without the macro, out_data=1625625 and out_sat=0; with the macro, out_data=262143 and out_sat=1.
REQ-032 pix=k, coef=2 for k=0..24, in_valid toggled every other cycle -> out_data=600 after 25 accepted beats.
REQ-033 Result ready with out_ready held 0 for 3 cycles -> out_data stable, in_ready=0, beats not consumed; accepted on out_ready=1, then IDLE.
REQ-034 rst (and separately clr) after 10 beats, then a full window of pix=2, coef=3 -> out_data=150.
REQ-035 Back-to-back windows with out_ready=1 -> one idle-accept gap between windows; second result independent of the first.
